// File: rtl/syscall_input_unit.sv
// Input-direction syscall responder: read_string (code 8) into byte-enabled memory,
// and read_int (code 5) decimal parsing when SYSCALL_READ_INT_EN is defined.
module syscall_input_unit #(
    parameter logic [31:0] HEAP_BASE = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sys_req,
    input  logic [31:0] sys_code,
    input  logic [31:0] sys_a0,
    input  logic [31:0] sys_a1,
    output logic        stall,
    output logic        sys_done,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        err
);

    typedef enum logic [2:0] {S_IDLE, S_STR, S_TERM, S_INT, S_DONE} state_t;

    // Address decode lives in the top level; the base only has to be word aligned.
    if (HEAP_BASE[1:0] != 2'b00) begin : g_bad_base
        $error("HEAP_BASE must be word aligned");
    end

    state_t      state, state_nxt;
    logic [31:0] ptr, rem;
    logic        code_str, code_int, start;

    assign code_str = (sys_code == 32'd8);
`ifdef SYSCALL_READ_INT_EN
    assign code_int = (sys_code == 32'd5);
`else
    assign code_int = 1'b0;
`endif
    assign start = sys_req && (code_str || code_int);

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (sys_req && code_str) begin
                    if (sys_a1 == 32'd0)      state_nxt = S_DONE;
                    else if (sys_a1 == 32'd1) state_nxt = S_TERM;
                    else                      state_nxt = S_STR;
                end else if (sys_req && code_int) begin
                    state_nxt = S_INT;
                end
            end
            S_STR: begin
                // rem==2 here means this store leaves room only for the NUL
                if (in_valid && (in_data == 8'h00 || in_data == 8'h0A || rem == 32'd2))
                    state_nxt = S_TERM;
            end
            S_TERM: state_nxt = S_DONE;
            S_INT: begin
                if (in_valid && (in_data == 8'h00 || in_data == 8'h0A))
                    state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // String pointer / remaining-length bookkeeping
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= 32'd0;
            rem <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sys_req && code_str) begin
                        ptr <= sys_a0;
                        rem <= sys_a1;
                    end
                end
                S_STR: begin
                    if (in_valid && in_data != 8'h00) begin
                        ptr <= ptr + 32'd1;
                        rem <= rem - 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SYSCALL_READ_INT_EN
    logic [31:0] acc;
    logic        neg, is_int, seen_digit, seen_sign, err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc        <= 32'd0;
            neg        <= 1'b0;
            is_int     <= 1'b0;
            seen_digit <= 1'b0;
            seen_sign  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc        <= 32'd0;
                        neg        <= 1'b0;
                        is_int     <= code_int;
                        seen_digit <= 1'b0;
                        seen_sign  <= 1'b0;
                        err_q      <= 1'b0;
                    end
                end
                S_INT: begin
                    if (in_valid) begin
                        if (in_data == 8'h0A || in_data == 8'h00) begin
                            // terminator: state machine moves to DONE
                        end else if (in_data >= 8'h30 && in_data <= 8'h39) begin
                            acc        <= acc * 32'd10 + {28'd0, in_data[3:0]};
                            seen_digit <= 1'b1;
                        end else if (in_data == 8'h20 && !seen_digit && !seen_sign) begin
                            // leading blank
                        end else if (in_data == 8'h2D && !seen_digit) begin
                            neg       <= 1'b1;
                            seen_sign <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Outputs are forced low while reset is asserted so nothing leaks during the reset cycle.
    always_comb begin
        stall    = 1'b0;
        in_ready = 1'b0;
        sys_done = 1'b0;
        rd_valid = 1'b0;
        rd_data  = 32'd0;
        mem_we   = 1'b0;
        mem_be   = 4'b0000;
        mem_addr = 32'd0;
        mem_din  = 32'd0;
        if (reset) begin
            case (state)
                S_IDLE: stall = start;
                S_STR: begin
                    stall    = 1'b1;
                    in_ready = 1'b1;
                    if (in_valid && in_data != 8'h00) begin
                        mem_we   = 1'b1;
                        mem_be   = 4'b1000 >> ptr[1:0];
                        mem_addr = {ptr[31:2], 2'b00};
                        mem_din  = {4{in_data}};
                    end
                end
                S_TERM: begin
                    stall    = 1'b1;
                    mem_we   = 1'b1;
                    mem_be   = 4'b1000 >> ptr[1:0];
                    mem_addr = {ptr[31:2], 2'b00};
                end
                S_INT: begin
                    stall    = 1'b1;
                    in_ready = 1'b1;
                end
                S_DONE: begin
                    sys_done = 1'b1;
`ifdef SYSCALL_READ_INT_EN
                    rd_valid = is_int;
                    if (is_int) rd_data = neg ? (~acc + 32'd1) : acc;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_syscall_input_unit.sv
// Scoreboard bench for syscall_input_unit: stimulus pushes expected writes/completions,
// a negedge monitor pops and compares them.
module tb_syscall_input_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sys_req = 1'b0;
    logic [31:0] sys_code = 32'd0, sys_a0 = 32'd0, sys_a1 = 32'd0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        stall, sys_done, rd_valid, in_ready, mem_we, err;
    logic [31:0] rd_data, mem_addr, mem_din;
    logic [3:0]  mem_be;

    syscall_input_unit dut (
        .clk(clk), .reset(reset), .sys_req(sys_req), .sys_code(sys_code),
        .sys_a0(sys_a0), .sys_a1(sys_a1), .stall(stall), .sys_done(sys_done),
        .rd_valid(rd_valid), .rd_data(rd_data), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_din(mem_din), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [31:0] addr; logic [3:0] be; logic [31:0] din;} wr_t;
    typedef struct packed {logic rv; logic [31:0] data; logic er;} dn_t;

    wr_t wr_q[$];
    dn_t dn_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [3:0] be, input logic [7:0] d);
        wr_q.push_back('{addr: a, be: be, din: {4{d}}});
    endtask

    task automatic exp_dn(input logic rv, input logic [31:0] d, input logic e);
        dn_q.push_back('{rv: rv, data: d, er: e});
    endtask

    // Monitor
    wr_t we;
    dn_t de;
    always @(negedge clk) begin
        if (mem_we) begin
            if (wr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write addr=%0h be=%b din=%0h", mem_addr, mem_be, mem_din);
            end else begin
                we = wr_q.pop_front();
                chk("wr_addr", mem_addr, we.addr);
                chk("wr_be", mem_be, we.be);
                chk("wr_din", mem_din, we.din);
            end
        end
        if (sys_done) begin
            if (dn_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done rd_valid=%0b rd_data=%0h", rd_valid, rd_data);
            end else begin
                de = dn_q.pop_front();
                chk("rd_valid", rd_valid, de.rv);
                chk("rd_data", rd_data, de.data);
                chk("err_at_done", err, de.er);
            end
        end
    end

    task automatic run(input logic [31:0] code, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [7:0] b[$], input bit gaps,
                       output int stalls, output int used, output int rdy, output int done_at);
        int n;
        bit fin;
        n = b.size();
        fin = 1'b0;
        stalls = 0; used = 0; rdy = 0; done_at = -1;
        sys_req = 1'b1; sys_code = code; sys_a0 = a0; sys_a1 = a1;
        for (int c = 0; c < 100 && !fin; c++) begin
            in_valid = (used < n) && !(gaps && c[0]);
            in_data  = (used < n) ? b[used] : 8'h00;
            #3;
            if (stall) stalls++;
            if (in_ready) rdy++;
            if (in_valid && in_ready) used++;
            if (sys_done) begin fin = 1'b1; done_at = c; end
            @(posedge clk); #1;
        end
        sys_req = 1'b0; in_valid = 1'b0;
        if (!fin) begin
            checks++; errors++;
            $display("FAIL timeout code=%0d a0=%0h", code, a0);
        end
    endtask

    initial begin
        logic [7:0] q[$];
        int st, us, rd, dn;

        // Reset: outputs low even with a request pending
        sys_req = 1'b1; sys_code = 32'd8; sys_a1 = 32'd4;
        @(posedge clk); #1;
        @(posedge clk); #3;
        chk("rst_stall", stall, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_done", sys_done, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_err", err, 0);
        sys_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // "hi\n" at unaligned 0x10000001
        exp_wr(32'h1000_0000, 4'b0100, 8'h68);
        exp_wr(32'h1000_0000, 4'b0010, 8'h69);
        exp_wr(32'h1000_0000, 4'b0001, 8'h0A);
        exp_wr(32'h1000_0004, 4'b1000, 8'h00);
        exp_dn(1'b0, 32'd0, 1'b0);
        q = '{8'h68, 8'h69, 8'h0A};
        run(32'd8, 32'h1000_0001, 32'd8, q, 1'b0, st, us, rd, dn);
        chk("hi_stall_cycles", st, 5);
        chk("hi_done_at", dn, 5);

        // Length limit: a1=3 takes two bytes then NUL
        exp_wr(32'h1000_0010, 4'b1000, 8'h61);
        exp_wr(32'h1000_0010, 4'b0100, 8'h62);
        exp_wr(32'h1000_0010, 4'b0010, 8'h00);
        exp_dn(1'b0, 32'd0, 1'b0);
        q = '{8'h61, 8'h62, 8'h63, 8'h64};
        run(32'd8, 32'h1000_0010, 32'd3, q, 1'b0, st, us, rd, dn);
        chk("lim_consumed", us, 2);
        chk("lim_ready_cycles", rd, 2);
        chk("lim_stall_cycles", st, 4);

        // Zero length
        exp_dn(1'b0, 32'd0, 1'b0);
        q = '{8'h41};
        run(32'd8, 32'h1000_0030, 32'd0, q, 1'b0, st, us, rd, dn);
        chk("zero_done_at", dn, 1);
        chk("zero_ready_cycles", rd, 0);
        chk("zero_stall_cycles", st, 1);

        // Address wrap past 0xFFFFFFFF
        exp_wr(32'hFFFF_FFFC, 4'b0001, 8'h7A);
        exp_wr(32'h0000_0000, 4'b1000, 8'h00);
        exp_dn(1'b0, 32'd0, 1'b0);
        q = '{8'h7A};
        run(32'd8, 32'hFFFF_FFFF, 32'd2, q, 1'b0, st, us, rd, dn);
        chk("wrap_stall_cycles", st, 3);

        // Embedded NUL ends the string without being stored
        exp_wr(32'h1000_0020, 4'b1000, 8'h71);
        exp_wr(32'h1000_0020, 4'b0100, 8'h00);
        exp_dn(1'b0, 32'd0, 1'b0);
        q = '{8'h71, 8'h00, 8'h72};
        run(32'd8, 32'h1000_0020, 32'd8, q, 1'b0, st, us, rd, dn);
        chk("nul_consumed", us, 2);

        // Gaps in in_valid add cycles one for one
        exp_wr(32'h1000_0000, 4'b0001, 8'h61);
        exp_wr(32'h1000_0004, 4'b1000, 8'h62);
        exp_wr(32'h1000_0004, 4'b0100, 8'h0A);
        exp_wr(32'h1000_0004, 4'b0010, 8'h00);
        exp_dn(1'b0, 32'd0, 1'b0);
        q = '{8'h61, 8'h62, 8'h0A};
        run(32'd8, 32'h1000_0003, 32'd8, q, 1'b1, st, us, rd, dn);
        chk("gap_stall_cycles", st, 8);

`ifdef SYSCALL_READ_INT_EN
        exp_dn(1'b1, 32'hFFFF_FF85, 1'b0);
        q = '{8'h20, 8'h2D, 8'h31, 8'h32, 8'h33, 8'h0A};
        run(32'd5, 32'd0, 32'd0, q, 1'b0, st, us, rd, dn);
        chk("int_neg_stall_cycles", st, 7);

        exp_dn(1'b1, 32'd12, 1'b1);
        q = '{8'h31, 8'h78, 8'h32, 8'h0A};
        run(32'd5, 32'd0, 32'd0, q, 1'b0, st, us, rd, dn);
        #3;
        chk("int_err_sticky", err, 1);
        #1;

        exp_dn(1'b1, 32'd7, 1'b0);
        q = '{8'h37, 8'h00};
        run(32'd5, 32'd0, 32'd0, q, 1'b0, st, us, rd, dn);

        // 4294967297 wraps to 1
        exp_dn(1'b1, 32'd1, 1'b0);
        q = '{8'h34, 8'h32, 8'h39, 8'h34, 8'h39, 8'h36, 8'h37, 8'h32, 8'h39, 8'h37, 8'h0A};
        run(32'd5, 32'd0, 32'd0, q, 1'b0, st, us, rd, dn);
`else
        // read_int unsupported: no stall, no ready, no completion
        sys_req = 1'b1; sys_code = 32'd5; in_valid = 1'b1; in_data = 8'h37;
        for (int c = 0; c < 4; c++) begin
            #3;
            chk("int_off_stall", stall, 0);
            chk("int_off_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        sys_req = 1'b0; in_valid = 1'b0;
`endif

        // Reset mid-string after two bytes (with gaps): no NUL written
        exp_wr(32'h1000_0040, 4'b1000, 8'h61);
        exp_wr(32'h1000_0040, 4'b0100, 8'h62);
        q = '{8'h61, 8'h62, 8'h63, 8'h64};
        sys_req = 1'b1; sys_code = 32'd8; sys_a0 = 32'h1000_0040; sys_a1 = 32'd8;
        us = 0;
        for (int c = 0; c < 40 && us < 2; c++) begin
            in_valid = c[0];
            in_data  = q[us];
            #3;
            if (in_valid && in_ready) us++;
            @(posedge clk); #1;
        end
        chk("rst_mid_consumed", us, 2);
        reset = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; sys_req = 1'b0;
        #3;
        chk("rst_mid_stall", stall, 0);
        chk("rst_mid_ready", in_ready, 0);
        chk("rst_mid_err", err, 0);
        #1;
        repeat (4) @(posedge clk);
        #1;

        chk("wr_q_empty", wr_q.size(), 0);
        chk("dn_q_empty", dn_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/syscall_input_unit.md
# syscall_input_unit

Hardware responder for the input-direction MIPS syscalls: `read_string` ($v0=8) and, optionally, `read_int` ($v0=5). It sits beside the datapath and controller in `MIPS_SCP`. On a decoded `SysCall` with a supported code it stalls the core and accepts bytes from a host byte stream. For `read_string` it writes the bytes, big-endian and byte-addressed, into data/heap memory through a byte-enabled write port. For `read_int` it parses a decimal integer and returns it for write-back to $v0. Output-direction syscalls (1, 4, 9, 10) are outside this block.

## Interface
Parameters:
- `HEAP_BASE`, 32'h10000000: informational only; address decode stays in the top level (`mem_addr` is the full byte address).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-low.
- `sys_req`  in  1  `SysCall` from the controller; level, held while the syscall instruction is current.
- `sys_code`  in  32  $v0 value.
- `sys_a0`  in  32  $a0: buffer byte address (code 8).
- `sys_a1`  in  32  $a1: buffer length in bytes, including the NUL (code 8).
- `stall`  out  1  freezes PC and register-file writes.
- `sys_done`  out  1  one-cycle completion pulse.
- `rd_valid`  out  1  $v0 write-back strobe (code 5 only).
- `rd_data`  out  32  parsed integer.
- `in_valid`  in  1  host byte valid.
- `in_data`  in  8  host byte.
- `in_ready`  out  1  unit accepts a byte this cycle.
- `mem_we`  out  1  memory write strobe.
- `mem_be`  out  4  byte enables; bit 3 is byte offset 0 (big-endian).
- `mem_addr`  out  32  word-aligned byte address ({addr[31:2],2'b00}).
- `mem_din`  out  32  write data; the byte is replicated in all four lanes.
- `err`  out  1  sticky parse error; cleared at the next accepted `sys_req`.

## Operation
- States: IDLE, STR, TERM, INT, DONE.
- Reset (`reset`=0 at a clock edge) forces IDLE. All outputs and internal registers are 0. `reset` overrides any state; a partial string is not NUL-terminated.
- IDLE:
  - With `sys_req`=1 and code 8: latch ptr=a0, rem=a1.
    - rem==0 → DONE.
    - rem==1 → TERM.
    - otherwise → STR.
  - With `sys_req`=1 and code 5 (macro only): clear acc, neg, err → INT.
  - Any other code: ignored, no stall.
- STR:
  - `in_ready`=1.
  - On `in_valid`: `mem_we`=1 with `mem_be`=4'b1000>>ptr[1:0], then ptr+=1 and rem-=1.
  - Byte 0x0A is stored, then → TERM.
  - Byte 0x00 → TERM without storing.
  - If rem reaches 1 after a store → TERM.
- TERM: one cycle. Writes 0x00 at ptr, `in_ready`=0, → DONE.
- INT:
  - `in_ready`=1.
  - ' ' (0x20) before any digit or sign: skipped.
  - '-' before any digit: sets neg.
  - '0'–'9': acc=acc*10+d, modulo 2^32 (overflow wraps silently).
  - 0x0A or 0x00: → DONE.
  - Any other byte: err=1, byte discarded, parsing continues.
- DONE: one cycle.
  - `sys_done`=1.
  - For code 5: `rd_valid`=1 and `rd_data`=neg ? -acc : acc (two's complement).
  - → IDLE. `sys_req` is not re-sampled in DONE.
- Address increment wraps modulo 2^32; no bounds check.

## Timing
- `stall` = (state∉{IDLE,DONE}) | (IDLE & `sys_req` & supported code). It is combinational so the core freezes in the syscall's first cycle.
- `stall`=0 in DONE, so the core retires the syscall at that edge together with the $v0 write.
- Memory writes are combinational from `in_valid`&`in_ready` and commit at the same edge as the byte accept. Writes are single-cycle with no read-modify-write.
- Minimum string latency: 1 (IDLE) + N bytes + 1 (TERM) + 1 (DONE) cycles. Gaps in `in_valid` add cycles one for one.
- `in_ready` never depends on `in_valid`.

## Configuration
- `SYSCALL_READ_INT_EN`:
  - Defined: state INT, the parser, and `rd_valid`/`rd_data`/`err` are functional.
  - Undefined: code 5 is treated as unsupported (no stall). `rd_valid`, `rd_data` and `err` are tied 0.

## Test plan
- `read_string` a0=0x10000001, a1=8, stream "hi\n" → writes:
  - addr 0x10000000 be=0100 0x68
  - addr 0x10000000 be=0010 0x69
  - addr 0x10000000 be=0001 0x0A
  - addr 0x10000004 be=1000 0x00
  - then `sys_done` once; `stall` high for exactly 5 cycles.
- a1=3, stream "abcd" → writes 'a', 'b', NUL; `in_ready`=0 when 'c' is offered; 'c' is not consumed.
- a1=0 → `sys_done` in the cycle after request; no `mem_we`; `in_ready` never 1.
- `read_int` " -123\n" → `rd_valid` with `rd_data`=0xFFFFFF85, `err`=0.
- `read_int` "1x2\n" → `rd_data`=12, `err`=1; macro undefined with code 5 → `stall`=0, no activity.
- `reset`=0 mid-string after 2 bytes, with `in_valid` gaps → next cycle state IDLE, `stall`=0, `in_ready`=0, no TERM write.
